// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: AXI4-Stream sample FIFO with a registered first-word-fall-through output.
// Capacity is 2^ADDR_WIDTH words: 2^ADDR_WIDTH-1 RAM entries plus the output register.
// Define AXIS_SAMPLE_FIFO_LOSSY_EN for lossy mode: the producer is never stalled, samples
// arriving while full are dropped and counted in ovf_count.
module axis_sample_fifo #(
    parameter int unsigned AXIS_DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH      = 10
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
    output logic [31:0]                ovf_count,
`endif
    output logic [ADDR_WIDTH:0]        fill_count
);

    localparam int unsigned           Depth    = 1 << ADDR_WIDTH;
    localparam int unsigned           RamDepth = Depth - 1;
    localparam logic [ADDR_WIDTH:0]   FillFull = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH-1:0] PtrLast  = ADDR_WIDTH'(RamDepth - 1);

    typedef enum logic [1:0] {StEmpty, StFetch, StValid} out_state_e;

    logic [AXIS_DATA_WIDTH-1:0] mem_q [RamDepth];
    logic [AXIS_DATA_WIDTH-1:0] rd_data_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
    out_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]      ram_cnt_q, ram_cnt_d;
    logic [ADDR_WIDTH:0]        fill_q, fill_d;
    logic                       full, wr_en, rd_en, consume;

    assign full    = (fill_q == FillFull);
    assign consume = (state_q == StValid) & m_axis_tready;
    // Refill the output stage whenever it is empty or being drained and the RAM has data.
    assign rd_en   = (ram_cnt_q != '0) & ((state_q == StEmpty) | consume);

`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
    logic [31:0] ovf_q, ovf_d;

    assign s_axis_tready = 1'b1;
    // Full is judged on the current level, so a same-cycle consume does not rescue the sample.
    assign wr_en         = s_axis_tvalid & ~full;
    assign ovf_count     = ovf_q;

    // Saturating count of samples dropped while full.
    always_comb begin
        ovf_d = ovf_q;
        if (s_axis_tvalid && full && (ovf_q != '1)) begin
            ovf_d = ovf_q + 32'd1;
        end
    end

    // Overflow counter register.
    always_ff @(posedge aclk) begin
        if (areset) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end
`else
    logic ready_q, ready_d;

    assign s_axis_tready = ready_q;
    assign wr_en         = s_axis_tvalid & ready_q;
    // Ready comes from the next fill level, so it never combinationally follows m_axis_tready.
    assign ready_d       = (fill_d != FillFull);

    // Input ready register; held low through reset.
    always_ff @(posedge aclk) begin
        if (areset) ready_q <= 1'b0;
        else        ready_q <= ready_d;
    end
`endif

    // Pointer, RAM occupancy and total fill bookkeeping.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        fill_d    = fill_q;
        if (wr_en) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        if (wr_en && !rd_en)      ram_cnt_d = ram_cnt_q + 1'b1;
        else if (!wr_en && rd_en) ram_cnt_d = ram_cnt_q - 1'b1;
        if (wr_en && !consume)      fill_d = fill_q + 1'b1;
        else if (!wr_en && consume) fill_d = fill_q - 1'b1;
    end

    // Output stage FSM: a fetch from EMPTY takes one cycle through rd_data_q; a consume in
    // VALID reloads straight from the RAM so streaming sustains one word per cycle.
    always_comb begin
        state_d = state_q;
        tdata_d = tdata_q;
        unique case (state_q)
            StEmpty: begin
                if (rd_en) state_d = StFetch;
            end
            StFetch: begin
                state_d = StValid;
                tdata_d = rd_data_q;
            end
            StValid: begin
                if (consume) begin
                    if (rd_en) tdata_d = mem_q[rd_ptr_q];
                    else       state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // RAM write port and registered read port; contents are never reset.
    always_ff @(posedge aclk) begin
        if (wr_en) mem_q[wr_ptr_q] <= s_axis_tdata;
        if (rd_en && (state_q == StEmpty)) rd_data_q <= mem_q[rd_ptr_q];
    end

    // Control and output registers; reset discards any in-flight read.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= StEmpty;
            tdata_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            tdata_q   <= tdata_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            fill_q    <= fill_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = (state_q == StValid);
    assign fill_count    = fill_q;

endmodule

// File: tb/tb_axis_sample_fifo.sv
// Self-checking bench for axis_sample_fifo (ADDR_WIDTH=4, 16 words). A queue-based model
// predicts every output each cycle; directed phases add literal expectations.
module tb_axis_sample_fifo;

    localparam int Depth = 16;
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
    localparam bit Lossy = 1'b1;
`else
    localparam bit Lossy = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [4:0]  fill_count;
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
    logic [31:0] ovf_count;
`endif

    always #5 clk = ~clk;

    axis_sample_fifo #(
        .AXIS_DATA_WIDTH(32),
        .ADDR_WIDTH     (4)
    ) dut (
        .aclk         (clk),
        .areset       (areset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
        .ovf_count    (ovf_count),
`endif
        .fill_count   (fill_count)
    );

    // Model: words held in order with the edge each was written on.
    logic [31:0] q_data[$];
    int          q_wr[$];
    int          edge_n    = 0;
    int          last_c    = -100;
    int          head_t    = 0;
    bit          exp_valid = 1'b0;
    bit          exp_ready = 1'b0;
    logic [31:0] exp_ovf   = '0;
    int          n_checks  = 0;
    int          n_pass    = 0;

    // A new head is presented on the edge the previous word is consumed if it was already
    // stored by then; otherwise two edges after it was written.
    function automatic int head_time(int w);
        return (last_c > w) ? last_c : w + 2;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic model_edge();
        bit full, wr, cons, drop;
        edge_n++;
        if (areset) begin
            q_data.delete();
            q_wr.delete();
            last_c    = -100;
            exp_ready = Lossy ? 1'b1 : 1'b0;
            exp_ovf   = '0;
        end else begin
            full = (q_data.size() == Depth);
            wr   = s_axis_tvalid && (Lossy ? !full : exp_ready);
            drop = Lossy && s_axis_tvalid && full;
            cons = exp_valid && m_axis_tready;
            if (cons) begin
                void'(q_data.pop_front());
                void'(q_wr.pop_front());
                last_c = edge_n;
                if (q_wr.size() > 0) head_t = head_time(q_wr[0]);
            end
            if (wr) begin
                q_data.push_back(s_axis_tdata);
                q_wr.push_back(edge_n);
                if (q_wr.size() == 1) head_t = head_time(edge_n);
            end
            if (drop && exp_ovf != 32'hFFFF_FFFF) exp_ovf = exp_ovf + 1;
            exp_ready = Lossy ? 1'b1 : (q_data.size() != Depth);
        end
        exp_valid = (q_data.size() > 0) && (edge_n >= head_t);
    endtask

    task automatic compare();
        chk("tvalid", 32'(m_axis_tvalid), 32'(exp_valid));
        chk("tready", 32'(s_axis_tready), 32'(exp_ready));
        chk("fill", 32'(fill_count), 32'(q_data.size()));
        if (exp_valid) chk("tdata", m_axis_tdata, q_data[0]);
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
        chk("ovf", ovf_count, exp_ovf);
`endif
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 64 && q_data.size() > 0; k++) cycle();
        chk("drain_empty", 32'(fill_count), 32'd0);
        m_axis_tready = 1'b0;
    endtask

    int pv[4] = '{70, 30, 90, 50};
    int pr[4] = '{30, 70, 90, 50};

    initial begin
        int j;
        int gaps;
        areset        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        m_axis_tready = 1'b0;

        // Reset held with tvalid asserted.
        repeat (3) cycle();
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        cycle();
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd1);
        chk("rst_tdata", m_axis_tdata, 32'd0);

        // Single word latency and hold.
        s_axis_tdata  = 32'hDEAD_BEEF;
        s_axis_tvalid = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
        cycle();
        chk("sw_lat1", 32'(m_axis_tvalid), 32'd0);
        cycle();
        chk("sw_lat2", 32'(m_axis_tvalid), 32'd1);
        chk("sw_model_valid", 32'(exp_valid), 32'd1);
        chk("sw_data", m_axis_tdata, 32'hDEAD_BEEF);
        chk("sw_fill", 32'(fill_count), 32'd1);
        repeat (3) cycle();
        chk("sw_hold", m_axis_tdata, 32'hDEAD_BEEF);
        m_axis_tready = 1'b1;
        cycle();
        m_axis_tready = 1'b0;
        chk("sw_cons_fill", 32'(fill_count), 32'd0);
        chk("sw_cons_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Fill with 20 words, no reads.
        for (int i = 0; i < 20; i++) begin
            s_axis_tdata  = 32'(i);
            s_axis_tvalid = 1'b1;
            cycle();
        end
        s_axis_tvalid = 1'b0;
        cycle();
        chk("full_fill", 32'(fill_count), 32'd16);
        chk("full_model_fill", 32'(q_data.size()), 32'd16);
`ifdef AXIS_SAMPLE_FIFO_LOSSY_EN
        chk("full_ovf", ovf_count, 32'd4);
        chk("full_model_ovf", exp_ovf, 32'd4);
        chk("full_tready", 32'(s_axis_tready), 32'd1);
`else
        chk("full_tready", 32'(s_axis_tready), 32'd0);
`endif
        m_axis_tready = 1'b1;
        j = 0;
        for (int k = 0; k < 40 && j < 16; k++) begin
            if (m_axis_tvalid === 1'b1) begin
                chk("full_order", m_axis_tdata, 32'(j));
                j++;
            end
            cycle();
        end
        m_axis_tready = 1'b0;
        chk("full_drained", 32'(j), 32'd16);
        chk("full_empty", 32'(fill_count), 32'd0);

        // Streaming at one word per cycle.
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 100; i++) begin
            s_axis_tdata = 32'h1000 + 32'(i);
            cycle();
            if (i >= 2 && m_axis_tvalid !== 1'b1) gaps++;
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_fill", 32'(fill_count), 32'd3);
        drain();

        // Write and consume on the same edge at fill 5.
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tdata = 32'h2000 + 32'(i);
            cycle();
        end
        s_axis_tvalid = 1'b0;
        repeat (2) cycle();
        chk("sim_fill_before", 32'(fill_count), 32'd5);
        chk("sim_head_before", m_axis_tdata, 32'h2000);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h2005;
        m_axis_tready = 1'b1;
        cycle();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        chk("sim_fill_after", 32'(fill_count), 32'd5);
        chk("sim_model_fill", 32'(q_data.size()), 32'd5);
        chk("sim_head_after", m_axis_tdata, 32'h2001);
        drain();

        // Randomized traffic across fill regimes, with one reset mid-stream.
        for (int ph = 0; ph < 4; ph++) begin
            for (int k = 0; k < 500; k++) begin
                s_axis_tvalid = ($urandom_range(99) < 32'(pv[ph]));
                m_axis_tready = ($urandom_range(99) < 32'(pr[ph]));
                s_axis_tdata  = $urandom;
                areset        = (ph == 2 && k == 250);
                cycle();
            end
        end
        areset = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
